scarv_cop_issue_bridge: RTL and testbench
=========================================

Name: scarv_cop_issue_bridge

Overview:
CPU-side bridge directly upstream of scarv_cop_top. It accepts instructions from the CPU pipeline over a valid/ready port and drives the COP req/ack dispatch handshake, including aborts. It collects COP responses into a small buffer and presents them to the CPU GPR writeback port.

Parameters:
MAX_OUTSTANDING, 2, max instructions acked by the COP but not yet responded; counter width $clog2(MAX_OUTSTANDING+1).
RSP_DEPTH, 2, response FIFO entries (power of 2, >=2).
WDOG_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
g_clk  in  1  global clock
g_resetn  in  1  synchronous active-low reset
cpu_valid  in  1  CPU offers instruction
cpu_ready  out  1  bridge accepts instruction
cpu_enc  in  32  CPU instruction encoding
cpu_rs1_in  in  32  CPU RS1 value
cpu_flush  in  1  CPU pipeline flush
cpu_insn_req  out  1  COP dispatch request
cop_insn_ack  in  1  COP dispatch acknowledge
cpu_abort_req  out  1  abort pending dispatch
cpu_insn_enc  out  32  latched encoding to COP
cpu_rs1  out  32  latched RS1 to COP
cop_wen  in  1  COP GPR write enable
cop_waddr  in  5  COP GPR address
cop_wdata  in  32  COP GPR data
cop_result  in  3  COP execution result
cop_insn_rsp  in  1  COP response valid
cpu_insn_ack  out  1  response accepted
wb_valid  out  1  writeback entry available
wb_ready  in  1  CPU consumes writeback
gpr_wen  out  1  head entry write enable
gpr_waddr  out  5  head entry address
gpr_wdata  out  32  head entry data
wb_result  out  3  head entry result
proto_err  out  1  sticky protocol error

Behaviour:
- Reset (g_resetn=0 at posedge, synchronous, active-low): FSM=IDLE; outstanding=0; FIFO empty; proto_err=0. Issue registers, cpu_insn_req, cpu_abort_req, cpu_ready and wb_valid are 0. All gpr_*/wb_result outputs are 0 while empty.
- Reset mid-operation discards the pending dispatch, outstanding count and buffered responses.
- FSM IDLE: cpu_ready = (outstanding < MAX_OUTSTANDING).
  - On cpu_valid&&cpu_ready, latch cpu_enc/cpu_rs1_in into cpu_insn_enc/cpu_rs1 and go to REQ.
  - cpu_insn_req rises the cycle after acceptance.
- FSM REQ: cpu_insn_req=1 and cpu_ready=0. Encoding and RS1 are held stable.
  - Dispatch transfer = req&&ack sampled at posedge. Go to IDLE (req low next cycle) and increment outstanding.
- Flush in REQ with ack=0: cpu_abort_req=1 for exactly one cycle (registered). Then return to IDLE, drop req and clear the issue registers. Outstanding is unchanged.
- Flush in REQ with ack=1 in the same cycle: the transfer wins and no abort is raised.
- Flush in IDLE: no effect. Flush does not affect outstanding responses; they are still collected.
- Response side: cpu_insn_ack = (fifo_count < RSP_DEPTH), combinational from registered count, with no bypass of a same-cycle pop.
  - Response transfer = cop_insn_rsp&&cpu_insn_ack. Push {cop_result,cop_wen,cop_waddr,cop_wdata} and decrement outstanding.
- Dispatch and response transfer in the same cycle: outstanding is unchanged.
- Response transfer with outstanding==0: entry is still pushed, outstanding stays 0 (no wrap), and proto_err is set. proto_err clears only on reset.
- Writeback: wb_valid = FIFO not empty. gpr_*/wb_result show the head entry, and gpr_wen is qualified by wb_valid.
  - Pop on wb_valid&&wb_ready.
  - Push and pop in the same cycle on a full FIFO is impossible (ack=0). On a non-empty, non-full FIFO, count is unchanged.
- Pointers wrap modulo RSP_DEPTH.
- Minimum latency: cpu accept -> req at +1 cycle. COP response -> wb_valid at +1 cycle.

Optional Feature:
SCARV_COP_ISSUE_BRIDGE_WDOG_EN: adds output wdog_err (1 bit, reset 0, sticky) and a cycle counter.
- Counter clears on any response transfer or when outstanding==0.
- Otherwise the counter increments, saturating at WDOG_CYCLES. wdog_err sets when the count reaches WDOG_CYCLES.
- Without the macro: no counter and no wdog_err port; WDOG_CYCLES is unused.

Test Plan:
- Reset for 2 cycles with cpu_valid=1 -> cpu_ready=0, req=0, wb_valid=0. First accept after release; req=1 the next cycle with cpu_insn_enc=0x0000_1234.
- Hold ack=0 for 5 cycles, then ack=1 -> req high for 6 cycles with enc/rs1 stable. Req low the cycle after transfer; outstanding=1.
- Dispatch 2 instructions with no responses (MAX_OUTSTANDING=2) -> cpu_ready=0. Inject rsp {result=0,wen=1,waddr=5,wdata=0xDEADBEEF} -> wb_valid=1, gpr_waddr=5, gpr_wdata=0xDEADBEEF, and cpu_ready returns.
- Hold wb_ready=0 and send 3 responses -> cpu_insn_ack=0 after 2 pushes. Then pulse wb_ready for one cycle -> ack=1 and the third response is accepted, preserving FIFO order.
- cpu_flush while req=1, ack=0 -> cpu_abort_req=1 for one cycle, req=0, outstanding unchanged. cpu_flush coincident with ack=1 -> no abort, outstanding+1.
- cop_insn_rsp with outstanding=0 -> proto_err=1, held until reset. With WDOG_EN and WDOG_CYCLES=10: one dispatch, no response -> wdog_err=1 ten cycles after the transfer.

Source files
------------

// File: rtl/scarv_cop_issue_bridge_if.sv
// CPU/COP signal bundle for the COP issue bridge.
// master: the bridge itself; slave: the CPU pipeline and COP around it.
interface scarv_cop_issue_bridge_if;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_enc;
  logic [31:0] cpu_rs1_in;
  logic        cpu_flush;
  logic        cpu_insn_req;
  logic        cop_insn_ack;
  logic        cpu_abort_req;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  logic        cop_wen;
  logic [4:0]  cop_waddr;
  logic [31:0] cop_wdata;
  logic [2:0]  cop_result;
  logic        cop_insn_rsp;
  logic        cpu_insn_ack;
  logic        wb_valid;
  logic        wb_ready;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [2:0]  wb_result;
  logic        proto_err;

  modport master (
    input  cpu_valid, cpu_enc, cpu_rs1_in, cpu_flush,
    input  cop_insn_ack,
    input  cop_wen, cop_waddr, cop_wdata, cop_result,
    input  cop_insn_rsp, wb_ready,
    output cpu_ready, cpu_insn_req, cpu_abort_req,
    output cpu_insn_enc, cpu_rs1, cpu_insn_ack,
    output wb_valid, gpr_wen, gpr_waddr, gpr_wdata,
    output wb_result, proto_err
  );

  modport slave (
    output cpu_valid, cpu_enc, cpu_rs1_in, cpu_flush,
    output cop_insn_ack,
    output cop_wen, cop_waddr, cop_wdata, cop_result,
    output cop_insn_rsp, wb_ready,
    input  cpu_ready, cpu_insn_req, cpu_abort_req,
    input  cpu_insn_enc, cpu_rs1, cpu_insn_ack,
    input  wb_valid, gpr_wen, gpr_waddr, gpr_wdata,
    input  wb_result, proto_err
  );
endinterface

// File: rtl/scarv_cop_issue_bridge.sv
// CPU-side issue bridge in front of scarv_cop_top: dispatch + response FIFO.
// Optional watchdog: define SCARV_COP_ISSUE_BRIDGE_WDOG_EN.
module scarv_cop_issue_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RSP_DEPTH       = 2,
  parameter int unsigned WDOG_CYCLES     = 255
) (
  input  logic g_clk,
  input  logic g_resetn,
`ifdef SCARV_COP_ISSUE_BRIDGE_WDOG_EN
  output logic wdog_err,
`endif
  scarv_cop_issue_bridge_if.master bus
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [0:0] FSM_IDLE = 1'b0;
  localparam logic [0:0] FSM_REQ  = 1'b1;

  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] FIFO_MAX = CW'(RSP_DEPTH);

  typedef struct packed {
    logic [2:0]  result;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rsp_t;

  logic [0:0]    fsm;
  logic [OW-1:0] outstanding;
  logic [31:0]   enc_q;
  logic [31:0]   rs1_q;
  logic          abort_q;
  logic          perr_q;

  rsp_t          mem [RSP_DEPTH];
  rsp_t          head;
  rsp_t          entry;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic is_idle;
  logic is_req;
  logic accept;
  logic dispatch;
  logic abort;
  logic push;
  logic pop;
  logic dec;

  assign is_idle  = (fsm == FSM_IDLE);
  assign is_req   = (fsm == FSM_REQ);
  assign accept   = bus.cpu_valid && bus.cpu_ready;
  assign dispatch = is_req && bus.cop_insn_ack;
  assign abort    = is_req && bus.cpu_flush
                 && !bus.cop_insn_ack;
  assign push     = bus.cop_insn_rsp && bus.cpu_insn_ack;
  assign pop      = bus.wb_valid && bus.wb_ready;
  assign dec      = push && (outstanding != '0);

  assign bus.cpu_ready     = g_resetn && is_idle
                          && (outstanding < OUT_MAX);
  assign bus.cpu_insn_req  = is_req;
  assign bus.cpu_abort_req = abort_q;
  assign bus.cpu_insn_enc  = enc_q;
  assign bus.cpu_rs1       = rs1_q;
  assign bus.proto_err     = perr_q;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      fsm     <= FSM_IDLE;
      enc_q   <= '0;
      rs1_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort;
      unique case (1'b1)
        accept: begin
          fsm   <= FSM_REQ;
          enc_q <= bus.cpu_enc;
          rs1_q <= bus.cpu_rs1_in;
        end
        dispatch: fsm <= FSM_IDLE;
        abort: begin
          fsm   <= FSM_IDLE;
          enc_q <= '0;
          rs1_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // An unexpected response never wraps the count; it flags proto_err.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      outstanding <= '0;
      perr_q      <= 1'b0;
    end else begin
      if (dispatch && !dec)
        outstanding <= outstanding + OW'(1);
      else if (dec && !dispatch)
        outstanding <= outstanding - OW'(1);
      if (push && (outstanding == '0))
        perr_q <= 1'b1;
    end
  end

  assign entry = '{
    result: bus.cop_result,
    wen:    bus.cop_wen,
    waddr:  bus.cop_waddr,
    wdata:  bus.cop_wdata
  };

  assign bus.cpu_insn_ack = g_resetn && (count < FIFO_MAX);

  always_ff @(posedge g_clk) begin
    if (push)
      mem[wr_ptr] <= entry;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.wb_valid  = (count != '0);
  assign bus.gpr_wen   = bus.wb_valid && head.wen;
  assign bus.gpr_waddr = bus.wb_valid ? head.waddr  : '0;
  assign bus.gpr_wdata = bus.wb_valid ? head.wdata  : '0;
  assign bus.wb_result = bus.wb_valid ? head.result : '0;

`ifdef SCARV_COP_ISSUE_BRIDGE_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WMAX = WW'(WDOG_CYCLES);

  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_nxt;
  logic          wclr;

  always_comb begin
    wclr     = push || (outstanding == '0);
    wcnt_nxt = wcnt;
    if (wclr)
      wcnt_nxt = '0;
    else if (wcnt != WMAX)
      wcnt_nxt = wcnt + WW'(1);
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wcnt     <= '0;
      wdog_err <= 1'b0;
    end else begin
      wcnt <= wcnt_nxt;
      if (!wclr && (wcnt_nxt == WMAX))
        wdog_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_scarv_cop_issue_bridge.sv
// Directed bench for scarv_cop_issue_bridge: response-table vectors
// plus hand sequences for dispatch, flush, reset and watchdog.
module tb_scarv_cop_issue_bridge;

  logic g_clk = 1'b0;
  logic g_resetn;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_issue_bridge_if bus ();

`ifdef SCARV_COP_ISSUE_BRIDGE_WDOG_EN
  logic wdog_err;
`endif

  scarv_cop_issue_bridge #(
    .MAX_OUTSTANDING(2),
    .RSP_DEPTH(2),
    .WDOG_CYCLES(10)
  ) dut (
    .g_clk(g_clk),
    .g_resetn(g_resetn),
`ifdef SCARV_COP_ISSUE_BRIDGE_WDOG_EN
    .wdog_err(wdog_err),
`endif
    .bus(bus)
  );

  typedef struct {
    logic        rsp;
    logic [2:0]  res;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        wbr;
    logic        e_ack;
    logic        e_val;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [2:0]  e_res;
    logic        e_perr;
  } vec_t;

  vec_t vt [10];

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic dispatch(input logic [31:0] enc);
    bus.cpu_valid = 1'b1;
    bus.cpu_enc   = enc;
    tick();
    bus.cpu_valid    = 1'b0;
    bus.cop_insn_ack = 1'b1;
    tick();
    bus.cop_insn_ack = 1'b0;
  endtask

  task automatic rsp_idle();
    bus.cop_insn_rsp = 1'b0;
    bus.cop_wen      = 1'b0;
    bus.cop_waddr    = '0;
    bus.cop_wdata    = '0;
    bus.cop_result   = '0;
  endtask

  function automatic vec_t mk(
    input logic rsp, input logic [2:0] res, input logic wen,
    input logic [4:0] addr, input logic [31:0] data, input logic wbr,
    input logic e_ack, input logic e_val, input logic e_wen,
    input logic [4:0] e_addr, input logic [31:0] e_data,
    input logic [2:0] e_res, input logic e_perr);
    vec_t v;
    v.rsp = rsp; v.res = res; v.wen = wen;
    v.addr = addr; v.data = data; v.wbr = wbr;
    v.e_ack = e_ack; v.e_val = e_val; v.e_wen = e_wen;
    v.e_addr = e_addr; v.e_data = e_data;
    v.e_res = e_res; v.e_perr = e_perr;
    return v;
  endfunction

  initial begin
    // Outstanding is 2 when the table starts; FIFO depth 2.
    vt[0] = mk(1, 1, 1, 1, 32'h11111111, 0,
               1, 1, 1, 1, 32'h11111111, 1, 0);
    vt[1] = mk(1, 2, 0, 2, 32'h22222222, 0,
               0, 1, 1, 1, 32'h11111111, 1, 0);
    vt[2] = mk(1, 3, 1, 3, 32'h33333333, 0,
               0, 1, 1, 1, 32'h11111111, 1, 0);
    vt[3] = mk(1, 3, 1, 3, 32'h33333333, 1,
               1, 1, 0, 2, 32'h22222222, 2, 0);
    vt[4] = mk(1, 3, 1, 3, 32'h33333333, 0,
               0, 1, 0, 2, 32'h22222222, 2, 1);
    vt[5] = mk(0, 0, 0, 0, 32'h0, 1,
               1, 1, 1, 3, 32'h33333333, 3, 1);
    vt[6] = mk(0, 0, 0, 0, 32'h0, 1,
               1, 0, 0, 0, 32'h0, 0, 1);
    vt[7] = mk(1, 4, 1, 4, 32'h44444444, 0,
               1, 1, 1, 4, 32'h44444444, 4, 1);
    vt[8] = mk(1, 5, 1, 31, 32'h55555555, 1,
               1, 1, 1, 31, 32'h55555555, 5, 1);
    vt[9] = mk(0, 0, 0, 0, 32'h0, 1,
               1, 0, 0, 0, 32'h0, 0, 1);

    g_resetn         = 1'b0;
    bus.cpu_valid    = 1'b1;
    bus.cpu_enc      = 32'h0000_1234;
    bus.cpu_rs1_in   = 32'hCAFE_0001;
    bus.cpu_flush    = 1'b0;
    bus.cop_insn_ack = 1'b0;
    bus.wb_ready     = 1'b0;
    rsp_idle();

    tick();
    tick();
    chk("rst ready", 32'(bus.cpu_ready), 0);
    chk("rst req", 32'(bus.cpu_insn_req), 0);
    chk("rst wb_valid", 32'(bus.wb_valid), 0);
    chk("rst proto", 32'(bus.proto_err), 0);
    chk("rst enc", bus.cpu_insn_enc, 0);
    chk("rst gpr_wdata", bus.gpr_wdata, 0);

    g_resetn = 1'b1;
    #1;
    chk("rel ready", 32'(bus.cpu_ready), 1);
    tick();
    bus.cpu_valid = 1'b0;
    chk("acc req", 32'(bus.cpu_insn_req), 1);
    chk("acc enc", bus.cpu_insn_enc, 32'h0000_1234);
    chk("acc rs1", bus.cpu_rs1, 32'hCAFE_0001);
    chk("acc ready", 32'(bus.cpu_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold req%0d", i), 32'(bus.cpu_insn_req), 1);
      chk($sformatf("hold enc%0d", i), bus.cpu_insn_enc, 32'h0000_1234);
      chk($sformatf("hold rs1%0d", i), bus.cpu_rs1, 32'hCAFE_0001);
    end
    bus.cop_insn_ack = 1'b1;
    tick();
    bus.cop_insn_ack = 1'b0;
    chk("xfer req", 32'(bus.cpu_insn_req), 0);
    chk("xfer ready", 32'(bus.cpu_ready), 1);

    dispatch(32'h0000_000A);
    chk("max ready", 32'(bus.cpu_ready), 0);

    bus.cop_insn_rsp = 1'b1;
    bus.cop_wen      = 1'b1;
    bus.cop_waddr    = 5'd5;
    bus.cop_wdata    = 32'hDEAD_BEEF;
    chk("rsp ack", 32'(bus.cpu_insn_ack), 1);
    tick();
    rsp_idle();
    chk("rsp wb_valid", 32'(bus.wb_valid), 1);
    chk("rsp gpr_wen", 32'(bus.gpr_wen), 1);
    chk("rsp waddr", 32'(bus.gpr_waddr), 5);
    chk("rsp wdata", bus.gpr_wdata, 32'hDEAD_BEEF);
    chk("rsp ready", 32'(bus.cpu_ready), 1);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk("pop wb_valid", 32'(bus.wb_valid), 0);
    chk("pop wdata", bus.gpr_wdata, 0);

    dispatch(32'h0000_000B);
    chk("refill ready", 32'(bus.cpu_ready), 0);

    for (int i = 0; i < 10; i++) begin
      bus.cop_insn_rsp = vt[i].rsp;
      bus.cop_result   = vt[i].res;
      bus.cop_wen      = vt[i].wen;
      bus.cop_waddr    = vt[i].addr;
      bus.cop_wdata    = vt[i].data;
      bus.wb_ready     = vt[i].wbr;
      tick();
      chk($sformatf("row%0d ack", i), 32'(bus.cpu_insn_ack), 32'(vt[i].e_ack));
      chk($sformatf("row%0d valid", i), 32'(bus.wb_valid), 32'(vt[i].e_val));
      chk($sformatf("row%0d wen", i), 32'(bus.gpr_wen), 32'(vt[i].e_wen));
      chk($sformatf("row%0d addr", i), 32'(bus.gpr_waddr), 32'(vt[i].e_addr));
      chk($sformatf("row%0d data", i), bus.gpr_wdata, vt[i].e_data);
      chk($sformatf("row%0d res", i), 32'(bus.wb_result), 32'(vt[i].e_res));
      chk($sformatf("row%0d perr", i), 32'(bus.proto_err), 32'(vt[i].e_perr));
    end
    rsp_idle();
    bus.wb_ready = 1'b0;

    bus.cpu_valid = 1'b1;
    bus.cpu_enc   = 32'h0000_F00D;
    tick();
    bus.cpu_valid = 1'b0;
    chk("fl req", 32'(bus.cpu_insn_req), 1);
    bus.cpu_flush = 1'b1;
    tick();
    bus.cpu_flush = 1'b0;
    chk("fl abort", 32'(bus.cpu_abort_req), 1);
    chk("fl req low", 32'(bus.cpu_insn_req), 0);
    chk("fl enc clr", bus.cpu_insn_enc, 0);
    chk("fl ready", 32'(bus.cpu_ready), 1);
    tick();
    chk("fl abort end", 32'(bus.cpu_abort_req), 0);

    bus.cpu_valid = 1'b1;
    bus.cpu_enc   = 32'h0000_BEEF;
    tick();
    bus.cpu_valid    = 1'b0;
    bus.cpu_flush    = 1'b1;
    bus.cop_insn_ack = 1'b1;
    tick();
    bus.cpu_flush    = 1'b0;
    bus.cop_insn_ack = 1'b0;
    chk("flx abort", 32'(bus.cpu_abort_req), 0);
    chk("flx req", 32'(bus.cpu_insn_req), 0);
    chk("flx ready", 32'(bus.cpu_ready), 1);
    dispatch(32'h0000_000C);
    chk("flx full", 32'(bus.cpu_ready), 0);
    bus.cpu_flush = 1'b1;
    tick();
    bus.cpu_flush = 1'b0;
    chk("idle flush", 32'(bus.cpu_abort_req), 0);
    chk("perr held", 32'(bus.proto_err), 1);

    bus.cop_insn_rsp = 1'b1;
    bus.cop_wdata    = 32'h0000_0077;
    tick();
    rsp_idle();
    bus.cpu_valid = 1'b1;
    bus.cpu_enc   = 32'h0000_0077;
    tick();
    bus.cpu_valid = 1'b0;
    chk("mid req", 32'(bus.cpu_insn_req), 1);
    chk("mid wb_valid", 32'(bus.wb_valid), 1);
    g_resetn = 1'b0;
    tick();
    chk("mrst req", 32'(bus.cpu_insn_req), 0);
    chk("mrst wb_valid", 32'(bus.wb_valid), 0);
    chk("mrst perr", 32'(bus.proto_err), 0);
    chk("mrst enc", bus.cpu_insn_enc, 0);
    g_resetn = 1'b1;
    #1;
    dispatch(32'h0000_000D);
    chk("mrst outst", 32'(bus.cpu_ready), 1);

`ifdef SCARV_COP_ISSUE_BRIDGE_WDOG_EN
    g_resetn = 1'b0;
    tick();
    chk("wd rst", 32'(wdog_err), 0);
    g_resetn = 1'b1;
    #1;
    dispatch(32'h0000_000E);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk($sformatf("wd quiet%0d", i), 32'(wdog_err), 0);
    end
    tick();
    chk("wd fire", 32'(wdog_err), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
